// File: rtl/axi_grant_return.sv
// Routes a shared downstream response stream back to requesters in grant order via an in-order FIFO.
// Optional macro AXI_GRANT_RETURN_ORPHAN_CHECK_EN: sink beats arriving with no grant and flag orphan_err.
module axi_grant_return #(
   parameter int unsigned WID   = 16,
   parameter int unsigned AWID  = $clog2(WID),
   parameter int unsigned DEPTH = 8,
   parameter int unsigned DWID  = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_vld,
   input  logic [AWID-1:0]            push_pos,
   output logic                       push_rdy,
   input  logic                       resp_vld,
   input  logic [DWID-1:0]            resp_data,
   input  logic                       resp_last,
   output logic                       resp_rdy,
   output logic [WID-1:0]             out_vld,
   output logic [DWID-1:0]            out_data,
   output logic                       out_last,
   input  logic [WID-1:0]             out_rdy,
`ifdef AXI_GRANT_RETURN_ORPHAN_CHECK_EN
   output logic                       orphan_err,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [AWID-1:0] slot_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [AWID-1:0] head;
   logic            nonempty, head_ok, push_fire, pop_fire;

   assign head      = slot_q[rd_ptr_q];
   assign nonempty  = (count_q != '0);
   assign head_ok   = nonempty && (32'(head) < WID);
   assign push_rdy  = (count_q < CW'(DEPTH));
   assign push_fire = push_vld && push_rdy;
   assign pop_fire  = nonempty && resp_vld && resp_rdy && resp_last;
   assign count     = count_q;

   always_comb begin
      out_vld  = '0;
      resp_rdy = 1'b0;
      out_data = resp_data;
      out_last = resp_last;
      if (head_ok) begin
         out_vld  = {{(WID-1){1'b0}}, resp_vld} << head;
         resp_rdy = out_rdy[head];
      end else if (nonempty) begin
         // Head names no real requester: sink the burst.
         resp_rdy = 1'b1;
      end
`ifdef AXI_GRANT_RETURN_ORPHAN_CHECK_EN
      else begin
         resp_rdy = 1'b1;
      end
`endif
   end

   always_comb begin
      count_d = count_q;
      unique case ({push_fire, pop_fire})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_fire)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Slot contents are only read when counted valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (push_fire) slot_q[wr_ptr_q] <= push_pos;
   end

`ifdef AXI_GRANT_RETURN_ORPHAN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    orphan_err <= 1'b0;
      else if (resp_vld && !nonempty) orphan_err <= 1'b1;
   end
`endif

endmodule
